shift_sequencer: RTL and testbench

Multi-cycle shift controller for the Simple RISC Machine datapath. It repeatedly drives the existing single-step `shifter` (op codes 00 = pass, 01 = left by 1 with zero fill, 10 = logical right by 1, 11 = arithmetic right by 1) to produce an N-position shift. It uses a start/busy/done handshake. It sits between the control FSM and the ALU B-operand path, and holds its result until the next accepted start.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_sequencer_if.sv | 33 +++
 rtl/shift_sequencer_shifter.sv | 24 ++
 rtl/shift_sequencer.sv | 93 +++++++++
 tb/tb_shift_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: op codes, FSM states
// and default widths.
package shift_pkg;

  localparam int SHIFT_W  = 16;
  localparam int SHIFT_CW = 4;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic op_is_pass(input logic [1:0] op);
    return (op == SH_NONE);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/busy/done handshake bundle for shift_sequencer.
// Z exists only when SHIFT_SEQ_ZF_EN is defined.
interface shift_sequencer_if #(
  parameter int W  = shift_pkg::SHIFT_W,
  parameter int CW = shift_pkg::SHIFT_CW
);
  logic          start;
  logic [W-1:0]  in;
  logic [1:0]    shift;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [W-1:0]  sout;
`ifdef SHIFT_SEQ_ZF_EN
  logic          Z;
`endif

  modport master (
    output start, in, shift, count,
    input  busy, done, sout
`ifdef SHIFT_SEQ_ZF_EN
    , input Z
`endif
  );

  modport slave (
    input  start, in, shift, count,
    output busy, done, sout
`ifdef SHIFT_SEQ_ZF_EN
    , output Z
`endif
  );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-step shifter: pass, LSL by 1, LSR by 1, ASR by 1.
module shifter
  import shift_pkg::*;
#(
  parameter int W = SHIFT_W
) (
  input  logic [W-1:0] in,
  input  logic [1:0]   shift,
  output logic [W-1:0] sout
);

  // One-position shift selected by op code
  always_comb begin
    sout = in;
    case (shift)
      SH_NONE: sout = in;
      SH_LSL:  sout = {in[W-2:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[W-1:1]};
      SH_ASR:  sout = {in[W-1], in[W-1:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller iterating the single-step shifter N times.
// Optional zero flag Z is enabled by defining SHIFT_SEQ_ZF_EN.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int W  = SHIFT_W,
  parameter int CW = SHIFT_CW
) (
  input logic               clk,
  input logic               reset,
  shift_sequencer_if.slave  bus
);

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  step_s;
  logic          accept_s;

  shifter #(.W(W)) u_shifter (
    .in    (data_q),
    .shift (op_q),
    .sout  (step_s)
  );

  // Next-state and datapath selection; start is ignored while shifting
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    accept_s = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        data_d = step_s;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_IDLE, ST_DONE: begin
        accept_s = bus.start;
        if (bus.start) begin
          data_d = bus.in;
          cnt_d  = bus.count;
          op_d   = bus.shift;
          if ((bus.count == {CW{1'b0}}) || op_is_pass(bus.shift)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and handshake registers; busy/done track the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      op_q    <= SH_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= (state_d == ST_SHIFT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sout = data_q;
`ifdef SHIFT_SEQ_ZF_EN
  assign bus.Z    = (data_q == {W{1'b0}});
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised and directed bench for shift_sequencer against a timeline model
// computing outputs from elapsed cycles since the last accepted start.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  shift_sequencer_if #(.W(16), .CW(4)) bus_if ();

  shift_sequencer #(.W(16), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: operation parameters plus cycles elapsed since acceptance
  logic        chk_en  = 1'b0;
  logic        m_valid = 1'b0;
  int          m_e     = 0;
  logic [15:0] m_in    = 16'h0000;
  logic [1:0]  m_op    = 2'b00;
  int          m_n     = 0;

  function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] op, input int k);
    logic signed [15:0] s;
    s = v;
    case (op)
      2'b01:   return v << k;
      2'b10:   return v >> k;
      2'b11:   return s >>> k;
      default: return v;
    endcase
  endfunction

  function automatic int neff();
    return (m_op == 2'b00 || m_n == 0) ? 0 : m_n;
  endfunction

  function automatic logic exp_busy();
    return m_valid && (m_e <= neff());
  endfunction

  function automatic logic exp_done();
    return m_valid && (m_e == neff() + 1);
  endfunction

  function automatic logic [15:0] exp_sout();
    if (!m_valid) return 16'h0000;
    return ref_shift(m_in, m_op, (m_e - 1 < neff()) ? m_e - 1 : neff());
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      chk_en  = 1'b1;
    end else if (bus_if.start && !exp_busy()) begin
      m_in    = bus_if.in;
      m_op    = bus_if.shift;
      m_n     = int'(bus_if.count);
      m_e     = 1;
      m_valid = 1'b1;
    end else if (m_valid && m_e < 40) begin
      m_e = m_e + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, bus_if.busy}, {31'd0, exp_busy()});
      check("done", {31'd0, bus_if.done}, {31'd0, exp_done()});
      check("sout", {16'd0, bus_if.sout}, {16'd0, exp_sout()});
`ifdef SHIFT_SEQ_ZF_EN
      check("zflag", {31'd0, bus_if.Z}, {31'd0, (exp_sout() == 16'h0000)});
`endif
    end
  end

  task automatic issue(input logic [15:0] v, input logic [1:0] op, input logic [3:0] n);
    bus_if.start = 1'b1;
    bus_if.in    = v;
    bus_if.shift = op;
    bus_if.count = n;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input logic [15:0] exp_v, input string name);
    int lat;
    lat = 0;
    while (!bus_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check(name, {16'd0, bus_if.sout}, {16'd0, exp_v});
  endtask

  initial begin
    int dones;
    bus_if.start = 1'b0;
    bus_if.in    = 16'h0000;
    bus_if.shift = 2'b00;
    bus_if.count = 4'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_done", {31'd0, bus_if.done}, 32'd0);
    check("rst_sout", {16'd0, bus_if.sout}, 32'd0);
`ifdef SHIFT_SEQ_ZF_EN
    check("rst_z", {31'd0, bus_if.Z}, 32'd1);
`endif

    issue(16'h0005, 2'b01, 4'd3);  wait_done(3, 16'h0028, "lsl3");
    issue(16'h8100, 2'b11, 4'd4);  wait_done(4, 16'hF810, "asr4");
    issue(16'h8100, 2'b10, 4'd4);  wait_done(4, 16'h0810, "lsr4");
    issue(16'h1234, 2'b01, 4'd0);  wait_done(0, 16'h1234, "cnt0");
    issue(16'h1234, 2'b00, 4'd15); wait_done(0, 16'h1234, "pass15");
    // Issued in the done cycle of the previous operation
    issue(16'h0001, 2'b01, 4'd15); wait_done(15, 16'h8000, "b2b");

    issue(16'h0003, 2'b01, 4'd8);
    repeat (2) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in    = 16'hFFFF;
    bus_if.shift = 2'b11;
    bus_if.count = 4'd2;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(5, 16'h0300, "ignored");

    @(negedge clk);
    issue(16'hAAAA, 2'b01, 4'd8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    check("abort_sout", {16'd0, bus_if.sout}, 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.done) dones++;
      @(negedge clk);
    end
    check("abort_nodone", dones, 32'd0);
    issue(16'h00FF, 2'b10, 4'd4); wait_done(4, 16'h000F, "after_rst");

`ifdef SHIFT_SEQ_ZF_EN
    issue(16'h0001, 2'b10, 4'd1); wait_done(1, 16'h0000, "z_one");
    check("z_set", {31'd0, bus_if.Z}, 32'd1);
    issue(16'h0003, 2'b10, 4'd1); wait_done(1, 16'h0001, "z_zero");
    check("z_clr", {31'd0, bus_if.Z}, 32'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      bus_if.start = ($urandom_range(0, 2) == 0);
      bus_if.in    = 16'($urandom);
      bus_if.shift = 2'($urandom_range(0, 3));
      bus_if.count = 4'($urandom_range(0, 15));
      reset        = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
